// File: rtl/ddr_m2a_rdata.sv
// rtl/ddr_m2a_rdata.sv - MBA-to-AXI read-return path: command/data buffering and R-channel replay
module ddr_m2a_rdata #(
  parameter int P_DEPTH  = 3,
  parameter int P_CDEPTH = 2,
  parameter int P_WIDTH  = 32,
  parameter int P_IDW    = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [P_IDW-1:0]   cmd_id_i,
  input  logic [7:0]         cmd_len_i,
  input  logic               mba_rvalid_i,
  input  logic [P_WIDTH-1:0] mba_rdata_i,
  input  logic               mba_rerr_i,
  output logic               rvalid_o,
  input  logic               rready_i,
  output logic [P_WIDTH-1:0] rdata_o,
  output logic [P_IDW-1:0]   rid_o,
  output logic [1:0]         rresp_o,
  output logic               rlast_o,
  output logic               err_o
);

  localparam int DEPTH  = 1 << P_DEPTH;
  localparam int CDEPTH = 1 << P_CDEPTH;
  localparam int RW     = P_DEPTH + 1;
  localparam int CPW    = P_CDEPTH + 1;
  localparam int CW     = (P_DEPTH + 2 > 9) ? P_DEPTH + 2 : 9;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  state_e             state_q, state_d;
  logic [7:0]         bcnt_q, bcnt_d;
  logic               err_q, err_d;
  logic [RW-1:0]      resv_q, resv_d;
  logic [CPW-1:0]     cwp_q, crp_q;
  logic [RW-1:0]      dwp_q, drp_q;

  logic [P_IDW-1:0]   cid_mem  [CDEPTH];
  logic [7:0]         clen_mem [CDEPTH];
  logic [P_WIDTH-1:0] ddat_mem [DEPTH];
  logic               derr_mem [DEPTH];

  logic               flush;
  logic [CPW-1:0]     c_count;
  logic               c_full, c_empty;
  logic [RW-1:0]      d_count;
  logic               d_empty;
  logic [CW-1:0]      need, avail, pend;
  logic               cmd_acc, overlong, beat_push, beat_drop;
  logic [7:0]         head_len;
  logic [P_IDW-1:0]   head_id;
  logic               rvalid, rlast, r_hs;

  assign flush   = reset_i | clr_i;
  assign c_count = cwp_q - crp_q;
  assign c_full  = (c_count == CPW'(CDEPTH));
  assign c_empty = (cwp_q == crp_q);
  assign d_count = dwp_q - drp_q;
  assign d_empty = (dwp_q == drp_q);

  // Credit check: a command is taken only if its whole burst fits in the data buffer.
  assign need        = CW'(cmd_len_i) + CW'(1);
  assign avail       = CW'(DEPTH) - CW'(resv_q);
  assign cmd_ready_o = ~flush & ~c_full & (need <= avail);
  assign cmd_acc     = cmd_valid_i & cmd_ready_o;
  assign overlong    = cmd_valid_i & (need > CW'(DEPTH));

  // Beats still owed by MBA; a command accepted this cycle already counts.
  assign pend      = CW'(resv_q) + (cmd_acc ? need : '0) - CW'(d_count);
  assign beat_push = mba_rvalid_i & (pend != '0);
  assign beat_drop = mba_rvalid_i & (pend == '0);

  assign head_len = clen_mem[crp_q[P_CDEPTH-1:0]];
  assign head_id  = cid_mem[crp_q[P_CDEPTH-1:0]];
  assign rvalid   = (state_q == S_BURST) & ~d_empty & ~flush;
  assign rlast    = (bcnt_q == head_len);
  assign r_hs     = rvalid & rready_i;

  assign rvalid_o = rvalid;
  assign rdata_o  = rvalid ? ddat_mem[drp_q[P_DEPTH-1:0]] : '0;
  assign rid_o    = rvalid ? head_id : '0;
  assign rresp_o  = (rvalid & derr_mem[drp_q[P_DEPTH-1:0]]) ? 2'b10 : 2'b00;
  assign rlast_o  = rvalid & rlast;
  assign err_o    = err_q & ~flush;

  assign resv_d = resv_q + (cmd_acc ? RW'(need) : '0) - (r_hs ? RW'(1) : '0);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q | overlong | beat_drop;
    case (state_q)
      S_IDLE: begin
        bcnt_d = '0;
        if (cmd_acc) state_d = S_BURST;
      end
      S_BURST: begin
        if (r_hs) begin
          if (rlast) begin
            bcnt_d = '0;
            if (c_count == CPW'(1) && !cmd_acc) state_d = S_IDLE;
          end else begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
      resv_q  <= '0;
      cwp_q   <= '0;
      crp_q   <= '0;
      dwp_q   <= '0;
      drp_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      resv_q  <= resv_d;
      if (cmd_acc)        cwp_q <= cwp_q + CPW'(1);
      if (r_hs && rlast)  crp_q <= crp_q + CPW'(1);
      if (beat_push)      dwp_q <= dwp_q + RW'(1);
      if (r_hs)           drp_q <= drp_q + RW'(1);
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (cmd_acc) begin
      cid_mem[cwp_q[P_CDEPTH-1:0]]  <= cmd_id_i;
      clen_mem[cwp_q[P_CDEPTH-1:0]] <= cmd_len_i;
    end
    if (beat_push) begin
      ddat_mem[dwp_q[P_DEPTH-1:0]] <= mba_rdata_i;
      derr_mem[dwp_q[P_DEPTH-1:0]] <= mba_rerr_i;
    end
  end

endmodule

// File: tb/tb_ddr_m2a_rdata.sv
// tb/tb_ddr_m2a_rdata.sv - scoreboard bench for ddr_m2a_rdata
module tb_ddr_m2a_rdata;

  logic        clk = 1'b0;
  logic        reset = 1'b1, clr = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_id = '0;
  logic [7:0]  cmd_len = '0;
  logic        mba_rvalid = 1'b0, mba_rerr = 1'b0;
  logic [31:0] mba_rdata = '0;
  logic        rvalid, rready = 1'b0, rlast, err;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  ddr_m2a_rdata #(.P_DEPTH(3), .P_CDEPTH(2), .P_WIDTH(32), .P_IDW(4)) dut (
    .clk_i(clk), .reset_i(reset), .clr_i(clr),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_id_i(cmd_id), .cmd_len_i(cmd_len),
    .mba_rvalid_i(mba_rvalid), .mba_rdata_i(mba_rdata), .mba_rerr_i(mba_rerr),
    .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .rid_o(rid),
    .rresp_o(rresp), .rlast_o(rlast), .err_o(err)
  );

  typedef struct packed {logic [3:0] id; logic last;} plan_t;
  typedef struct packed {logic [31:0] d; logic [3:0] id; logic last; logic [1:0] resp;} exp_t;

  plan_t plan_q[$];
  exp_t  sb_q[$];
  int    n_checks = 0, n_pass = 0, n_pops = 0;

  logic        s_cmd_ready, s_rvalid, s_rlast, s_err, s_hs;
  logic [31:0] s_rdata;
  logic [3:0]  s_rid;
  logic [1:0]  s_rresp;
  logic        stall_q = 1'b0;
  logic [38:0] held_q = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: sample at negedge, update the scoreboard, then return 1ns after posedge.
  task automatic tick();
    logic  acc;
    plan_t p;
    exp_t  x;
    acc = 1'b0;
    @(negedge clk);
    s_cmd_ready = cmd_ready; s_rvalid = rvalid; s_rlast = rlast; s_err = err;
    s_rdata = rdata; s_rid = rid; s_rresp = rresp; s_hs = rvalid & rready;
    if (reset || clr) begin
      plan_q.delete();
      sb_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q)
        check("hold", {rvalid, rdata, rid, rresp, rlast}, {1'b1, held_q});
      if (cmd_valid && cmd_ready) begin
        acc = 1'b1;
        for (int i = 0; i <= int'(cmd_len); i++) begin
          p.id = cmd_id;
          p.last = (i == int'(cmd_len));
          plan_q.push_back(p);
        end
      end
      if (rvalid && rready) begin
        n_pops++;
        if (sb_q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          x = sb_q.pop_front();
          check("rdata", rdata, x.d);
          check("rid", rid, x.id);
          check("rlast", rlast, x.last);
          check("rresp", rresp, x.resp);
        end
      end
      stall_q = rvalid & ~rready;
      held_q = {rdata, rid, rresp, rlast};
    end
    @(posedge clk);
    #1;
    if (acc) cmd_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic e);
    plan_t p;
    exp_t  x;
    mba_rvalid = 1'b1; mba_rdata = d; mba_rerr = e;
    if (plan_q.size() > 0) begin
      p = plan_q.pop_front();
      x.d = d; x.id = p.id; x.last = p.last; x.resp = e ? 2'b10 : 2'b00;
      sb_q.push_back(x);
    end
  endtask

  task automatic issue_cmd(input logic [3:0] id, input logic [7:0] len);
    cmd_id = id; cmd_len = len; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && cmd_valid; i++) tick();
    check("cmd_accept_timeout", cmd_valid, 0);
  endtask

  task automatic drain();
    rready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (plan_q.size() > 0) beat($urandom, 1'b0);
      else mba_rvalid = 1'b0;
      if (plan_q.size() == 0 && sb_q.size() == 0 && !mba_rvalid && !cmd_valid) break;
      tick();
    end
    check("drain_empty", sb_q.size() + plan_q.size(), 0);
  endtask

  task automatic clr_pulse();
    clr = 1'b1; tick();
    check("clr_err_out", s_err, 0);
    check("clr_cmd_ready", s_cmd_ready, 0);
    clr = 1'b0; tick();
    check("post_clr_err", s_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    // Reset: outputs zero while held, CMD_READY the first cycle after release
    repeat (3) tick();
    check("rst_outs", {s_cmd_ready, s_rvalid, s_rlast, s_rdata, s_rid, s_rresp, s_err}, '0);
    reset = 1'b0;
    tick();
    check("rst_ready_after", s_cmd_ready, 1);
    check("rst_err_after", s_err, 0);

    // Single burst ID 5 LEN 3
    issue_cmd(4'd5, 8'd3);
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin beat(32'hA0 + i, 1'b0); tick(); end
    mba_rvalid = 1'b0;
    drain();
    cmd_len = 8'd7; tick();
    check("resv_zero_full_credit", s_cmd_ready, 1);

    // Credit limit: LEN 7 fills the buffer, LEN 0 waits for the first pop
    issue_cmd(4'd3, 8'd7);
    cmd_id = 4'd4; cmd_len = 8'd0; cmd_valid = 1'b1; rready = 1'b0;
    for (int i = 0; i < 8; i++) begin beat(32'hC0 + i, 1'b0); tick(); end
    mba_rvalid = 1'b0; tick();
    check("credit_block", s_cmd_ready, 0);
    check("credit_rvalid", s_rvalid, 1);
    rready = 1'b1; tick();
    check("credit_pop_hs", s_hs, 1);
    check("credit_pop_cycle", s_cmd_ready, 0);
    tick();
    check("credit_after_pop", s_cmd_ready, 1);
    drain();

    // Backpressure with an errored third beat across two commands
    issue_cmd(4'd1, 8'd1);
    issue_cmd(4'd2, 8'd2);
    for (int i = 0; i < 6; i++) begin
      rready = 1'($urandom_range(1));
      beat(32'hB0 + i, i == 2);
      tick();
    end
    mba_rvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin rready = 1'($urandom_range(1)); tick(); end
    drain();

    // Unexpected beat sets sticky ERR without producing R traffic
    beat(32'hDEAD, 1'b0); tick();
    mba_rvalid = 1'b0; tick();
    check("unexp_err", s_err, 1);
    check("unexp_rvalid", s_rvalid, 0);
    repeat (3) tick();
    check("unexp_err_sticky", s_err, 1);
    clr_pulse();
    check("post_clr_ready", s_cmd_ready, 1);

    // Overlong command is refused and flags ERR
    cmd_id = 4'd7; cmd_len = 8'd8; cmd_valid = 1'b1; tick();
    check("overlong_ready", s_cmd_ready, 0);
    cmd_valid = 1'b0; tick();
    check("overlong_err", s_err, 1);
    clr_pulse();

    // Reset mid-burst discards everything; later beats are unexpected
    issue_cmd(4'd6, 8'd3);
    rready = 1'b0;
    beat(32'hE0, 1'b0); tick();
    beat(32'hE1, 1'b0); tick();
    mba_rvalid = 1'b0;
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    check("rst_mid_rvalid", s_rvalid, 0);
    beat(32'hE2, 1'b0); tick();
    mba_rvalid = 1'b0; tick();
    check("rst_mid_late_beat_err", s_err, 1);
    check("rst_mid_no_rvalid", s_rvalid, 0);
    clr_pulse();

    // Random soak
    base = n_pops;
    for (int c = 0; c < 4000; c++) begin
      if (!cmd_valid && $urandom_range(3) == 0) begin
        cmd_valid = 1'b1;
        cmd_len = 8'($urandom_range(7));
        cmd_id = 4'($urandom_range(15));
      end
      if (plan_q.size() > 0 && $urandom_range(9) < 7) beat($urandom, $urandom_range(7) == 0);
      else mba_rvalid = 1'b0;
      rready = ($urandom_range(9) < 7);
      tick();
    end
    drain();
    tick();
    check("soak_err", s_err, 0);
    check("soak_pops", (n_pops - base) > 500, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
